// File: rtl/ahbl_pkg.sv
// AHB-Lite encodings and helpers shared by the bus initiators and responders.
package ahbl_pkg;

  localparam int unsigned HADDR_W = 32;
  localparam int unsigned HDATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // Copy an LSB-justified write value onto every byte lane it may occupy.
  function automatic logic [HDATA_W-1:0] ahbl_replicate_wdata(
    input logic [1:0]         size,
    input logic [HDATA_W-1:0] data
  );
    logic [HDATA_W-1:0] rep;
    rep = data;
    case (size)
      2'd0:    rep = {4{data[7:0]}};
      2'd1:    rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/ahbl_sbus_master.sv
// Debug Module system-bus port to AHB-Lite manager bridge, one SINGLE transfer per request.
// Optional data-phase timeout with drain state: define AHBL_SBUS_TIMEOUT_EN.
module ahbl_sbus_master
  import ahbl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sbus_addr,
  input  logic        sbus_write,
  input  logic [1:0]  sbus_size,
  input  logic        sbus_vld,
  output logic        sbus_rdy,
  output logic        sbus_err,
  input  logic [31:0] sbus_wdata,
  output logic [31:0] sbus_rdata,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hmastlock,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ahbl_sbus_master: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t             r_state;
  htrans_t            r_htrans;
  logic [HADDR_W-1:0] r_addr;
  logic               r_write;
  logic [1:0]         r_size;
  logic [HDATA_W-1:0] r_wdata;
  logic [HDATA_W-1:0] r_hwdata;
  logic [HDATA_W-1:0] r_rdata;
  logic               r_rdy;
  logic               r_err;
  logic               w_misaligned;

`ifdef AHBL_SBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  // Timeout fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_wait_cnt;
`endif

  // Illegal size or address not aligned to the access size.
  always_comb begin
    w_misaligned = 1'b0;
    case (sbus_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = sbus_addr[0];
      2'd2:    w_misaligned = |sbus_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_htrans <= HTRANS_IDLE;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_wdata  <= '0;
      r_hwdata <= '0;
      r_rdata  <= '0;
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
`ifdef AHBL_SBUS_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        // r_rdy masks the cycle in which the DM still holds vld after a response.
        ST_IDLE: begin
          if (sbus_vld && !r_rdy) begin
            if (w_misaligned) begin
              r_rdy <= 1'b1;
              r_err <= 1'b1;
            end else begin
              r_addr   <= sbus_addr;
              r_write  <= sbus_write;
              r_size   <= sbus_size;
              r_wdata  <= sbus_wdata;
              r_htrans <= HTRANS_NONSEQ;
              r_state  <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (hready) begin
            r_htrans <= HTRANS_IDLE;
            r_hwdata <= ahbl_replicate_wdata(r_size, r_wdata);
            r_state  <= ST_DATA;
`ifdef AHBL_SBUS_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        ST_DATA: begin
          if (hready) begin
            r_rdy   <= 1'b1;
            r_err   <= hresp;
            r_state <= ST_IDLE;
            if (!hresp) begin
              r_rdata <= hrdata;
            end
          end
`ifdef AHBL_SBUS_TIMEOUT_EN
          else if (r_wait_cnt == TIMEOUT_LIM) begin
            r_rdy   <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_DRAIN;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`endif
        end
`ifdef AHBL_SBUS_TIMEOUT_EN
        // Let the stalled responder finish before issuing anything new.
        ST_DRAIN: begin
          if (hready) begin
            r_state <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_state  <= ST_IDLE;
          r_htrans <= HTRANS_IDLE;
        end
      endcase
    end
  end

  assign sbus_rdy   = r_rdy;
  assign sbus_err   = r_err;
  assign sbus_rdata = r_rdata;
  assign haddr      = r_addr;
  assign hwrite     = r_write;
  assign htrans     = r_htrans;
  assign hsize      = {1'b0, r_size};
  assign hwdata     = r_hwdata;
  assign hburst     = HBURST_SINGLE;
  assign hprot      = HPROT_DATA_PRIV;
  assign hmastlock  = 1'b0;

endmodule

// File: doc/ahbl_sbus_master.md
# ahbl_sbus_master

Bridges the Debug Module's system-bus access port (vld/rdy request, single transfer) onto an AHB-Lite manager port, making the DM a standalone bus initiator on the system fabric. It is the initiator-side counterpart of the AHB-Lite responders (SRAM, peripherals). It issues one NONSEQ single transfer per sbus request and returns read data or error on the sbus response.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: data-phase wait-state limit. Used only when `AHBL_SBUS_TIMEOUT_EN` is defined; legal range 1..65535.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `sbus_addr` in 32: byte address.
- `sbus_write` in 1: 1 = write.
- `sbus_size` in 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `sbus_vld` in 1: request valid; held with stable fields until `sbus_rdy`.
- `sbus_rdy` out 1: single-cycle response strobe.
- `sbus_err` out 1: error qualifier, valid with `sbus_rdy`.
- `sbus_wdata` in 32: write data, LSB-justified.
- `sbus_rdata` out 32: read data as seen on the bus lanes (not shifted), valid with `sbus_rdy`.
- `haddr` out 32; `hwrite` out 1; `htrans` out 2; `hsize` out 3; `hburst` out 3; `hprot` out 4; `hmastlock` out 1; `hwdata` out 32: AHB-Lite manager outputs.
- `hready` in 1; `hresp` in 1; `hrdata` in 32: AHB-Lite manager inputs.

## Operation
- Constant outputs: `hburst` = 0 (SINGLE), `hmastlock` = 0, `hprot` = 4'b0011 (privileged data). `hsize` = {1'b0, size}.
- States:
  - IDLE: accepts a request when `sbus_vld && !sbus_rdy`. The `sbus_rdy` term masks the cycle in which the DM is still holding `vld` after a response.
    - Misaligned or illegal size (size 3; size 1 with `addr[0]`; size 2 with `addr[1:0]` ≠ 0): next cycle `sbus_rdy` = `sbus_err` = 1, no bus traffic, stay in IDLE.
    - Otherwise: latch addr/write/size/wdata, go to ADDR.
  - ADDR: `htrans` = NONSEQ with latched `haddr`/`hwrite`/`hsize`. When `hready` = 1, go to DATA; otherwise hold all address-phase outputs.
  - DATA: `htrans` = IDLE. `hwdata` carries the latched wdata replicated across lanes (byte ×4, halfword ×2, word as-is) and is held for the whole data phase.
    - `hready && !hresp`: `sbus_rdy` = 1, `sbus_err` = 0, `sbus_rdata` = `hrdata`; go to IDLE.
    - `hresp` first cycle (`hready` = 0): keep `htrans` IDLE and wait.
    - `hready && hresp`: `sbus_rdy` = `sbus_err` = 1; go to IDLE.
  - DRAIN (timeout build only): `htrans` = IDLE, no sbus response. When `hready` = 1, go to IDLE. Requests are not accepted while in DRAIN.
- Reset values: state IDLE, `htrans` = 0, `haddr` = 0, `hwrite` = 0, `hsize` = 0, `hwdata` = 0, `sbus_rdy` = 0, `sbus_err` = 0, `sbus_rdata` = 0.
- Reset mid-transfer: outputs return to reset values on the next edge and the transfer is abandoned. This is permitted only because `rst` is a system-wide reset.

## Timing
- All outputs are registered. There are no combinational paths from any input to any output.
- Best-case latency, with `vld` sampled at edge 0 and zero wait states: NONSEQ visible in cycle 1, data phase in cycle 2, `sbus_rdy` high in cycle 3.
- Each address-phase or data-phase wait state adds one cycle.
- Error response: `sbus_rdy` is high one cycle after the second `hresp` cycle.
- Back-to-back requests: the earliest next NONSEQ is 2 cycles after `sbus_rdy`.

## Configuration
- `AHBL_SBUS_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to DATA and increments each DATA cycle with `hready` = 0.
  - When the count reaches `TIMEOUT_CYCLES`: next cycle `sbus_rdy` = `sbus_err` = 1, state goes to DRAIN.
  - A legitimate completion in the same cycle as the timeout takes priority and gives a normal response.
- `AHBL_SBUS_TIMEOUT_EN` undefined: no counter, DRAIN is unreachable, and a stalled slave blocks the bridge indefinitely.

## Structure
- Shared package `ahbl_pkg`:
  - `htrans_t` encodings (IDLE/BUSY/NONSEQ/SEQ).
  - `HSIZE_*` and `HBURST_SINGLE` constants.
  - `HPROT_DATA_PRIV` constant.
  - Function `ahbl_replicate_wdata(size, data)`.
- State enum is local to the module.
- No sub-module; single flat module.

## Test plan
- Word write 0xDEADBEEF to 0x00000100, responder with 0 wait states → `haddr` 0x100, `hsize` 2, NONSEQ for one cycle; `hwdata` 0xDEADBEEF; `sbus_rdy` 3 cycles after `vld`, `err` = 0.
- Byte read from 0x00000103, `hrdata` 0x11223344 with 2 data wait states → `hsize` 0, `sbus_rdata` 0x11223344, `rdy` in cycle 5; halfword write 0xABCD shows `hwdata` 0xABCDABCD.
- Halfword request at 0x00000001, and size 3 at 0x0 → `rdy` & `err` one cycle later, `htrans` never leaves IDLE.
- Two-cycle ERROR response on a word read → `htrans` IDLE throughout, `rdy` & `err` = 1 exactly once; next request proceeds normally.
- Timeout build with `TIMEOUT_CYCLES` = 4 and `hready` held low 10 cycles → `rdy` & `err` after the 4th wait cycle; DRAIN ignores a new `vld` until `hready` rises, then the request is issued.
- `rst` asserted during ADDR with `hready` low → next cycle `htrans` = 0, `sbus_rdy` = 0; no `rdy` ever appears for the abandoned request.
